cond_fork_n: RTL and testbench

//   Clocked N-way conditional fork for micropipeline control. One i_drive token is forwarded
//   as single-cycle drive pulses to every channel whose valid bit is set.

---
 rtl/cond_fork_n.sv | 135 +++++++++++++
 tb/tb_cond_fork_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_fork_n.sv
// cond_fork_n: N-way conditional fork for micropipeline control.
// One upstream drive token fans out as a single-cycle drive pulse to every
// selected channel; the returned free pulses are joined (all selected
// channels, or the first one in ANY mode) before a single free pulse is sent
// back upstream. All outputs are registered.
module cond_fork_n #(
   parameter int N         = 5,     // number of output channels (1..32)
   parameter bit FREE_MODE = 1'b0   // 0 = JOIN (all selected), 1 = ANY (first)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_drive,
   output logic         o_free,
   output logic [N-1:0] o_driveNext,
   input  logic [N-1:0] i_freeNext,
   input  logic [N-1:0] valid,
   output logic         o_busy,
   output logic         o_err_overrun,
   output logic         o_err_spurious,
   input  logic         i_err_clr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   drive_q, drive_d;
   logic           free_q, free_d;
   logic           busy_q, busy_d;
   logic           ovr_q, ovr_d;
   logic           spr_q, spr_d;

   // Pending mask after this cycle's frees are applied.
   logic [N-1:0]   pend_clr;
   // Condition that releases the token upstream while in ISSUE/WAIT.
   logic           join_done;
   logic           ovr_ev;
   logic           spr_ev;

   // Free-return bookkeeping and error events, shared by all states.
   always_comb begin
      pend_clr = pending_q & ~i_freeNext;
      // ANY: first returned free on a selected channel; JOIN: nothing left.
      if (FREE_MODE)
         join_done = |(pending_q & i_freeNext);
      else
         join_done = (pend_clr == '0);
      // In IDLE pending is empty, so every free there is spurious too.
      spr_ev = |(i_freeNext & ~pending_q);
      // Tokens can only be accepted in IDLE; anything else is dropped.
      ovr_ev = i_drive && (state_q != S_IDLE);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      drive_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (i_drive) begin
               pending_d = valid;
               if (valid != '0) begin
                  // Drive pulse appears the cycle after the token.
                  drive_d = valid;
                  state_d = S_ISSUE;
               end else begin
                  // Nothing selected: release the token right away.
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE, S_WAIT: begin
            pending_d = pend_clr;
            state_d   = join_done ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            // In JOIN mode pending is already empty here, so DRAIN is
            // only ever reached in ANY mode.
            pending_d = pend_clr;
            state_d   = (pend_clr == '0) ? S_IDLE : S_DRAIN;
         end
         S_DRAIN: begin
            // Swallow the late frees of the remaining selected channels.
            pending_d = pend_clr;
            if (pend_clr == '0)
               state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            pending_d = '0;
         end
      endcase
      // Outputs are registered from the next state so they line up with it.
      free_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
      // A new error event in the same cycle as a clear keeps the flag set.
      ovr_d  = (ovr_q & ~i_err_clr) | ovr_ev;
      spr_d  = (spr_q & ~i_err_clr) | spr_ev;
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         drive_q   <= '0;
         free_q    <= 1'b0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
         spr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         drive_q   <= drive_d;
         free_q    <= free_d;
         busy_q    <= busy_d;
         ovr_q     <= ovr_d;
         spr_q     <= spr_d;
      end
   end

   assign o_driveNext    = drive_q;
   assign o_free         = free_q;
   assign o_busy         = busy_q;
   assign o_err_overrun  = ovr_q;
   assign o_err_spurious = spr_q;

endmodule

// File: tb/tb_cond_fork_n.sv
// Bench for cond_fork_n: a JOIN and an ANY instance share one stimulus
// stream and are compared each cycle against a token-level reference model.
module tb_cond_fork_n;

   localparam int N = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              drv;
   logic              clr;
   logic [N-1:0]      vld;
   logic [N-1:0]      fr;

   logic [1:0]        free_o;
   logic [1:0][N-1:0] drv_o;
   logic [1:0]        busy_o;
   logic [1:0]        ovr_o;
   logic [1:0]        spr_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cond_fork_n #(.N(N), .FREE_MODE(1'b0)) u_join (
      .clk(clk), .rst(rst), .i_drive(drv), .o_free(free_o[0]),
      .o_driveNext(drv_o[0]), .i_freeNext(fr), .valid(vld),
      .o_busy(busy_o[0]), .o_err_overrun(ovr_o[0]),
      .o_err_spurious(spr_o[0]), .i_err_clr(clr));

   cond_fork_n #(.N(N), .FREE_MODE(1'b1)) u_any (
      .clk(clk), .rst(rst), .i_drive(drv), .o_free(free_o[1]),
      .o_driveNext(drv_o[1]), .i_freeNext(fr), .valid(vld),
      .o_busy(busy_o[1]), .o_err_overrun(ovr_o[1]),
      .o_err_spurious(spr_o[1]), .i_err_clr(clr));

   // Reference model, index 0 = JOIN, 1 = ANY. A token is "active" from the
   // accepting edge until all its selected channels have returned a free
   // (or, for an empty mask, until its o_free cycle has passed).
   bit           m_act[2];
   bit           m_freed[2];   // upstream free already emitted for token
   bit           m_fnow[2];    // expected o_free in the current cycle
   bit           m_ovr[2];
   bit           m_spr[2];
   logic [N-1:0] m_pend[2];
   logic [N-1:0] m_drv[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_act[m] = 0; m_freed[m] = 0; m_fnow[m] = 0;
         m_ovr[m] = 0; m_spr[m] = 0; m_pend[m] = '0; m_drv[m] = '0;
      end
   endtask

   // Advance model m across one clock edge with the inputs held this cycle.
   task automatic model_step(input int m, input bit d, input logic [N-1:0] v,
                             input logic [N-1:0] f, input bit c);
      bit           ovr_ev = 0;
      bit           spr_ev = 0;
      bit           nf     = 0;
      logic [N-1:0] nd     = '0;
      logic [N-1:0] np;
      if (!m_act[m]) begin
         spr_ev = (f != '0);
         if (d) begin
            m_act[m] = 1; m_pend[m] = v; m_freed[m] = 0; nd = v;
            if (v == '0) begin nf = 1; m_freed[m] = 1; end
         end
      end else begin
         ovr_ev = d;
         spr_ev = ((f & ~m_pend[m]) != '0);
         np = m_pend[m] & ~f;
         if (m_fnow[m] || m_freed[m]) begin
            if (np == '0) m_act[m] = 0;
         end else if (m == 0 ? (np == '0) : ((m_pend[m] & f) != '0)) begin
            nf = 1; m_freed[m] = 1;
         end
         m_pend[m] = np;
      end
      m_fnow[m] = nf;
      m_drv[m]  = nd;
      m_ovr[m]  = (m_ovr[m] && !c) || ovr_ev;
      m_spr[m]  = (m_spr[m] && !c) || spr_ev;
   endtask

   // Move to the sampling point and compare both instances with the model.
   task automatic tick();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("drive%0d", m), 32'(drv_o[m]), 32'(m_drv[m]));
         chk($sformatf("free%0d", m),  32'(free_o[m]), 32'(m_fnow[m]));
         chk($sformatf("busy%0d", m),  32'(busy_o[m]), 32'(m_act[m]));
         chk($sformatf("ovr%0d", m),   32'(ovr_o[m]), 32'(m_ovr[m]));
         chk($sformatf("spr%0d", m),   32'(spr_o[m]), 32'(m_spr[m]));
      end
   endtask

   task automatic apply(input bit d, input logic [N-1:0] v, input logic [N-1:0] f, input bit c);
      drv = d; vld = v; fr = f; clr = c;
      for (int m = 0; m < 2; m++) model_step(m, d, v, f, c);
   endtask

   task automatic cyc(input bit d, input logic [N-1:0] v, input logic [N-1:0] f, input bit c);
      tick();
      apply(d, v, f, c);
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
   task automatic do_reset();
      tick();
      drv = 0; vld = '0; fr = '0; clr = 0;
      rst = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rst_drive%0d", m), 32'(drv_o[m]), 32'd0);
         chk($sformatf("rst_free%0d", m),  32'(free_o[m]), 32'd0);
         chk($sformatf("rst_busy%0d", m),  32'(busy_o[m]), 32'd0);
         chk($sformatf("rst_err%0d", m),   32'({ovr_o[m], spr_o[m]}), 32'd0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int m = 0; m < 2; m++) model_step(m, 0, '0, '0, 0);
   endtask

   initial begin
      logic [N-1:0] p;
      logic [N-1:0] rv;
      logic [N-1:0] rf;
      int           r;
      rst = 1'b1; drv = 0; vld = '0; fr = '0; clr = 0;
      model_reset();
      tick();
      rst = 1'b0;
      apply(0, '0, '0, 0);

      // Basic JOIN: drive 10101, frees ch0/ch2/ch4 at t+3/t+5/t+6.
      cyc(1, 5'b10101, '0, 0);
      tick(); chk("t1_drive", 32'(drv_o[0]), 32'h15); apply(0, '0, '0, 0);
      tick(); chk("t1_drive_off", 32'(drv_o[0]), 32'h0); apply(0, '0, '0, 0);
      cyc(0, '0, 5'b00001, 0);
      cyc(0, '0, '0, 0);
      cyc(0, '0, 5'b00100, 0);
      tick(); chk("t1_free_early", 32'(free_o[0]), 32'd0); apply(0, '0, 5'b10000, 0);
      tick(); chk("t1_free", 32'(free_o[0]), 32'd1); apply(0, '0, '0, 0);
      tick(); chk("t1_free_off", 32'(free_o[0]), 32'd0); apply(0, '0, '0, 0);
      cyc(0, '0, '0, 1);

      // Empty mask: immediate free, busy drops again two cycles later.
      cyc(1, '0, '0, 0);
      tick(); chk("t2_free", 32'(free_o[0]), 32'd1); chk("t2_drive", 32'(drv_o[0]), 32'd0);
      apply(0, '0, '0, 0);
      tick(); chk("t2_busy", 32'(busy_o[0]), 32'd0); apply(0, '0, '0, 0);

      // ANY: free ch2 releases, ch1 drains later without a second free.
      cyc(1, 5'b00110, '0, 0);
      cyc(0, '0, '0, 0); cyc(0, '0, '0, 0); cyc(0, '0, '0, 0);
      cyc(0, '0, 5'b00100, 0);
      tick(); chk("t3_free", 32'(free_o[1]), 32'd1); apply(0, '0, '0, 0);
      tick(); chk("t3_drain_busy", 32'(busy_o[1]), 32'd1); apply(0, '0, '0, 0);
      cyc(0, '0, '0, 0);
      cyc(0, '0, 5'b00010, 0);
      tick(); chk("t3_idle", 32'(busy_o[1]), 32'd0); chk("t3_no_free", 32'(free_o[1]), 32'd0);
      apply(0, '0, '0, 1);
      cyc(0, '0, '0, 0);

      // Overrun: second drive while busy is dropped; clear removes the flag.
      cyc(1, 5'b00001, '0, 0);
      cyc(0, '0, '0, 0);
      cyc(1, 5'b00010, '0, 0);
      tick(); chk("t4_ovr", 32'(ovr_o[0]), 32'd1); chk("t4_no_drive", 32'(drv_o[0]), 32'd0);
      apply(0, '0, 5'b00001, 1);
      tick(); chk("t4_clr", 32'(ovr_o[0]), 32'd0); apply(0, '0, '0, 0);
      cyc(0, '0, '0, 0);

      // Spurious free on ch3 while only ch0 is pending.
      cyc(1, 5'b00001, '0, 0);
      cyc(0, '0, 5'b01000, 0);
      tick(); chk("t5_spr", 32'(spr_o[0]), 32'd1); chk("t5_wait", 32'(free_o[0]), 32'd0);
      apply(0, '0, 5'b00001, 0);
      tick(); chk("t5_free", 32'(free_o[0]), 32'd1); apply(0, '0, '0, 1);
      cyc(0, '0, '0, 0);

      // Reset while waiting with pending 00011; later frees are only spurious.
      cyc(1, 5'b00011, '0, 0);
      cyc(0, '0, '0, 0);
      cyc(0, '0, '0, 0);
      do_reset();
      cyc(0, '0, 5'b00011, 0);
      tick(); chk("t6_spr", 32'(spr_o[0]), 32'd1); chk("t6_busy", 32'(busy_o[0]), 32'd0);
      chk("t6_free", 32'(free_o[0]), 32'd0);
      apply(0, '0, '0, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            p  = m_pend[0] | m_pend[1];
            rv = N'($urandom);
            if ($urandom_range(0, 5) == 0) rv = '0;
            r  = $urandom_range(0, 9);
            if (r == 0)     rf = N'($urandom);
            else if (r < 6) rf = N'($urandom) & p;
            else            rf = '0;
            cyc($urandom_range(0, 3) == 0, rv, rf, $urandom_range(0, 15) == 0);
         end
      end
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
